// File: rtl/warp_dispatch_scheduler_if.sv
// Warp dispatch scheduler bus.
// Groups the launch request, the descriptor issue channel and the warp
// completion channel into one bundle.
//   master : scheduler view (drives launch_ready, out_*, status)
//   slave  : environment view (drives launch, out_ready, finish)
// Signals:
//   launch_kernel / launch_ready          kernel launch handshake
//   num_incoming_threads[c], starting_pc[c]  per-core launch payload
//   out_valid / out_ready                 descriptor issue handshake
//   out_warp_id, out_core_id, out_pc, out_thread_mask  descriptor fields
//   finish_valid, finish_warp_id          warp completion (ID release)
//   active_warps, idle, release_error     status
interface warp_dispatch_scheduler_if #(
    parameter int NUM_SIMD_CORES   = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int MAX_WARPS        = 16,
    parameter int PC_W             = 32
);
    localparam int CID_W = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
    localparam int TC_W  = $clog2(THREADS_PER_WARP + 1);
    localparam int WID_W = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;
    localparam int AW_W  = $clog2(MAX_WARPS + 1);

    logic                                 launch_kernel;
    logic                                 launch_ready;
    logic [NUM_SIMD_CORES-1:0][TC_W-1:0]  num_incoming_threads;
    logic [NUM_SIMD_CORES-1:0][PC_W-1:0]  starting_pc;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [WID_W-1:0]                     out_warp_id;
    logic [CID_W-1:0]                     out_core_id;
    logic [PC_W-1:0]                      out_pc;
    logic [THREADS_PER_WARP-1:0]          out_thread_mask;
    logic                                 finish_valid;
    logic [WID_W-1:0]                     finish_warp_id;
    logic [AW_W-1:0]                      active_warps;
    logic                                 idle;
    logic                                 release_error;

    modport master (
        input  launch_kernel, num_incoming_threads, starting_pc,
               out_ready, finish_valid, finish_warp_id,
        output launch_ready, out_valid, out_warp_id, out_core_id, out_pc,
               out_thread_mask, active_warps, idle, release_error
    );

    modport slave (
        output launch_kernel, num_incoming_threads, starting_pc,
               out_ready, finish_valid, finish_warp_id,
        input  launch_ready, out_valid, out_warp_id, out_core_id, out_pc,
               out_thread_mask, active_warps, idle, release_error
    );
endinterface

// File: rtl/warp_dispatch_scheduler.sv
// Warp dispatch scheduler.
// Expands a kernel launch (thread count + PC per SIMD core) into one warp
// descriptor per non-empty core, queues the descriptors, tags each with the
// lowest free warp ID when it enters the output register, and issues it over
// a valid/ready handshake. Completed warps return their IDs to the pool.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  warp_dispatch_scheduler_if.master (launch, issue, finish, status)
module warp_dispatch_scheduler #(
    parameter int NUM_SIMD_CORES   = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int MAX_WARPS        = 16,
    parameter int QUEUE_DEPTH      = 8,
    parameter int PC_W             = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    warp_dispatch_scheduler_if.master        bus
);
    localparam int CID_W = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
    localparam int TC_W  = $clog2(THREADS_PER_WARP + 1);
    localparam int WID_W = (MAX_WARPS > 1) ? $clog2(MAX_WARPS) : 1;
    localparam int AW_W  = $clog2(MAX_WARPS + 1);
    localparam int QA_W  = $clog2(QUEUE_DEPTH);

    function automatic logic [TC_W-1:0] clamp_cnt(input logic [TC_W-1:0] n);
        return (n > TC_W'(THREADS_PER_WARP)) ? TC_W'(THREADS_PER_WARP) : n;
    endfunction

    function automatic logic [THREADS_PER_WARP-1:0] lane_mask(input logic [TC_W-1:0] n);
        logic [THREADS_PER_WARP-1:0] m;
        for (int k = 0; k < THREADS_PER_WARP; k++) begin
            m[k] = (TC_W'(k) < n);
        end
        return m;
    endfunction

    // Staging: one slot per core, present bit cleared as each slot is pushed
    logic [NUM_SIMD_CORES-1:0] r_stg_vld;
    logic [PC_W-1:0]           r_stg_pc  [NUM_SIMD_CORES];
    logic [TC_W-1:0]           r_stg_cnt [NUM_SIMD_CORES];

    // Descriptor FIFO; pointers carry one extra wrap bit
    logic [CID_W-1:0] r_q_cid [QUEUE_DEPTH];
    logic [PC_W-1:0]  r_q_pc  [QUEUE_DEPTH];
    logic [TC_W-1:0]  r_q_cnt [QUEUE_DEPTH];
    logic [QA_W:0]    r_wr_ptr;
    logic [QA_W:0]    r_rd_ptr;

    // Warp ID pool and output register
    logic [MAX_WARPS-1:0]        r_alloc;
    logic [AW_W-1:0]             r_active;
    logic                        r_rel_err;
    logic                        r_out_valid;
    logic [WID_W-1:0]            r_out_wid;
    logic [CID_W-1:0]            r_out_cid;
    logic [PC_W-1:0]             r_out_pc;
    logic [THREADS_PER_WARP-1:0] r_out_mask;

    logic                 w_launch_ready;
    logic                 w_accept;
    logic                 w_stg_any;
    logic [CID_W-1:0]     w_stg_sel;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_any_free;
    logic [WID_W-1:0]     w_free_id;
    logic                 w_fid_alloc;
    logic                 w_load;
    logic                 w_rel_ok;
    logic                 w_rel_bad;
    logic [MAX_WARPS-1:0] w_set_mask;
    logic [MAX_WARPS-1:0] w_clr_mask;

    assign w_launch_ready = ~|r_stg_vld;
    assign w_accept       = bus.launch_kernel && w_launch_ready;

    // Lowest-index present core: descending scan so the last hit wins
    always_comb begin
        w_stg_any = 1'b0;
        w_stg_sel = '0;
        for (int c = NUM_SIMD_CORES - 1; c >= 0; c--) begin
            if (r_stg_vld[c]) begin
                w_stg_any = 1'b1;
                w_stg_sel = CID_W'(c);
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[QA_W] != r_rd_ptr[QA_W]) &&
                     (r_wr_ptr[QA_W-1:0] == r_rd_ptr[QA_W-1:0]);
    assign w_push  = w_stg_any && !w_full;

    // Allocation looks only at the pre-edge pool, so an ID freed this cycle
    // becomes allocatable one cycle later.
    always_comb begin
        w_any_free  = 1'b0;
        w_free_id   = '0;
        w_fid_alloc = 1'b0;
        for (int i = MAX_WARPS - 1; i >= 0; i--) begin
            if (!r_alloc[i]) begin
                w_any_free = 1'b1;
                w_free_id  = WID_W'(i);
            end
            if (bus.finish_warp_id == WID_W'(i)) begin
                w_fid_alloc = r_alloc[i];
            end
        end
    end

    assign w_load    = (!r_out_valid || bus.out_ready) && !w_empty && w_any_free;
    assign w_rel_ok  = bus.finish_valid && w_fid_alloc;
    assign w_rel_bad = bus.finish_valid && !w_fid_alloc;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 0; i < MAX_WARPS; i++) begin
            w_set_mask[i] = w_load && (w_free_id == WID_W'(i));
            w_clr_mask[i] = w_rel_ok && (bus.finish_warp_id == WID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_vld <= '0;
        end else if (w_accept) begin
            for (int c = 0; c < NUM_SIMD_CORES; c++) begin
                r_stg_vld[c] <= (bus.num_incoming_threads[c] != '0);
            end
        end else if (w_push) begin
            r_stg_vld[w_stg_sel] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < NUM_SIMD_CORES; c++) begin
                r_stg_pc[c]  <= bus.starting_pc[c];
                r_stg_cnt[c] <= clamp_cnt(bus.num_incoming_threads[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_cid[r_wr_ptr[QA_W-1:0]] <= w_stg_sel;
            r_q_pc[r_wr_ptr[QA_W-1:0]]  <= r_stg_pc[w_stg_sel];
            r_q_cnt[r_wr_ptr[QA_W-1:0]] <= r_stg_cnt[w_stg_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc     <= '0;
            r_active    <= '0;
            r_rel_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_cid   <= '0;
            r_out_pc    <= '0;
            r_out_mask  <= '0;
        end else begin
            r_alloc <= (r_alloc & ~w_clr_mask) | w_set_mask;
            case ({w_load, w_rel_ok})
                2'b10:   r_active <= r_active + AW_W'(1);
                2'b01:   r_active <= r_active - AW_W'(1);
                default: r_active <= r_active;
            endcase
            if (w_rel_bad) r_rel_err <= 1'b1;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_wid   <= w_free_id;
                r_out_cid   <= r_q_cid[r_rd_ptr[QA_W-1:0]];
                r_out_pc    <= r_q_pc[r_rd_ptr[QA_W-1:0]];
                r_out_mask  <= lane_mask(r_q_cnt[r_rd_ptr[QA_W-1:0]]);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.launch_ready    = w_launch_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_warp_id     = r_out_wid;
    assign bus.out_core_id     = r_out_cid;
    assign bus.out_pc          = r_out_pc;
    assign bus.out_thread_mask = r_out_mask;
    assign bus.active_warps    = r_active;
    assign bus.release_error   = r_rel_err;
    assign bus.idle            = w_launch_ready && w_empty && !r_out_valid &&
                                 (r_active == '0);
endmodule

// File: doc/warp_dispatch_scheduler.md
Name: warp_dispatch_scheduler

Overview:
Parametrised successor to the single-kernel warp scheduler. Accepts a kernel launch carrying a per-SIMD-core thread count and starting PC, and expands it into one warp descriptor per non-empty core. Descriptors are buffered in a FIFO, a warp ID is allocated to each from a free pool, and they are issued to the SIMD cores over a valid/ready handshake. Warp completions return IDs to the pool.

Parameters:
NUM_SIMD_CORES, 4, number of per-core launch slots; core_id width CID_W = max(1,$clog2(NUM_SIMD_CORES))
THREADS_PER_WARP, 8, lanes per warp; thread count width TC_W = $clog2(THREADS_PER_WARP+1)
MAX_WARPS, 16, warp IDs in the pool; ID width WID_W = $clog2(MAX_WARPS)
QUEUE_DEPTH, 8, pending-descriptor FIFO depth (power of 2, >=2)
PC_W, 32, program counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
launch_kernel  in  1  launch request, sampled when launch_ready=1
launch_ready  out  1  staging register empty, launch can be accepted
num_incoming_threads  in  [TC_W-1:0] x NUM_SIMD_CORES  threads per core; 0 = core unused
starting_pc  in  [PC_W-1:0] x NUM_SIMD_CORES  starting PC per core
out_valid  out  1  descriptor valid
out_ready  in  1  consumer accepts descriptor
out_warp_id  out  WID_W  allocated warp ID
out_core_id  out  CID_W  target SIMD core
out_pc  out  PC_W  starting PC
out_thread_mask  out  THREADS_PER_WARP  active lanes, (1<<n)-1
finish_valid  in  1  a warp has completed
finish_warp_id  in  WID_W  ID of completed warp
active_warps  out  $clog2(MAX_WARPS+1)  allocated-ID count
idle  out  1  staging empty, FIFO empty, out_valid=0, active_warps=0
release_error  out  1  sticky; set when finish_valid names an unallocated ID

Behaviour:
- Reset (async): staging cleared, FIFO empty, pool all free, out_valid=0, out_* fields=0, active_warps=0, release_error=0, launch_ready=1, idle=1.
- Launch: at an edge with launch_kernel=1 and launch_ready=1, all count/PC inputs are snapshotted into staging. Cores with count 0 are marked absent. launch_kernel with launch_ready=0 is ignored and is not queued. An all-zero launch is accepted and produces nothing.
- Staging drain: each cycle with the FIFO not full, the lowest-index present core is pushed as {core_id, pc, count} and cleared from staging. launch_ready returns to 1 on the edge after the last push. Drain stalls while the FIFO is full.
- Count clamp: a count greater than THREADS_PER_WARP is clamped to THREADS_PER_WARP.
- Issue: the output register loads the FIFO head when (out_valid=0 or out_ready=1), the FIFO is non-empty, and at least one ID is free.
  - The ID is the lowest free ID.
  - Mask bit k = (k < count).
- Handshake: the transfer completes on an edge with out_valid and out_ready both 1. While out_valid=1 and out_ready=0, all out_* fields stay stable. With out_ready held high, back-to-back issue runs at one per cycle.
- Latency: launch sampled at edge N, first push at edge N+1, out_valid at edge N+2 at the earliest.
- ID pool: the ID is allocated when loaded into the output register, not at the handshake.
  - finish_valid frees the ID at that edge. The freed ID is not allocatable until the next edge, because allocation uses the pre-edge pool.
  - Simultaneous allocate and free: active_warps changes by net 0.
  - Freeing a free ID: no state change, release_error set until reset.
- FIFO: full and empty are detected with a wrap bit on the pointers. Pointers wrap modulo QUEUE_DEPTH. There is no overflow, because pushes only occur when the FIFO is not full.
- Pool exhaustion: with no free ID, the head waits and out_valid drops after the pending transfer. Issue resumes the cycle after a release.
- Reset mid-operation: everything is discarded, including staged, queued and issued warps and allocated IDs.

Test Plan:
- Basic launch: counts {4,2,7,3}, PCs {FFFF_FFFE, 8765_4321, ABCD_EF01, 1010_1010}, out_ready=1 → four descriptors in core order 0..3.
  - IDs 0,1,2,3; masks 0x0F, 0x03, 0x7F, 0x07.
  - Matching PCs; first out_valid 2 cycles after launch; active_warps=4.
- Skip and clamp: counts {0,9,0,1} → two descriptors: core 1 with mask 0xFF, and core 3 with mask 0x01. A launch during the drain is ignored.
- Backpressure: out_ready=0 for 5 cycles after the first out_valid → the fields hold stable. Release → remaining descriptors issue one per cycle.
- Pool exhaustion (MAX_WARPS=2): 4-core launch → IDs 0 and 1 issue, then out_valid=0. finish_warp_id=1 → the next descriptor gets ID 1 one cycle later. Simultaneous finish and issue keeps active_warps constant.
- FIFO full (QUEUE_DEPTH=2), out_ready=0 → staging stalls and launch_ready stays 0. Lowering and raising out_ready drains everything in order. A bad release (finish ID 5 while free) → release_error=1.
- Reset mid-drain: assert rst asynchronously mid-clock-cycle, between rising edges, during drain → immediate out_valid=0, idle=1, active_warps=0. A fresh launch restarts at ID 0.
